// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 N-bit demultiplexer.
// Lane indices double as the encoding of the 2-bit select input.
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_e;

endpackage : demux_pkg

// File: rtl/demux_lane_reg.sv
// One output lane of the demux: a BUS_WIDTH register that captures y when
// its lane is selected and clears to zero otherwise, every cycle.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int    BUS_WIDTH = 8,
  parameter lane_e LANE_IDX  = LANE_A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] y,
  input  lane_e                sel,
  output logic [BUS_WIDTH-1:0] q
);

  logic [BUS_WIDTH-1:0] lane_d;
  logic [BUS_WIDTH-1:0] lane_q;

  // No hold state: a deselected lane is forced to zero rather than kept.
  always_comb begin
    lane_d = '0;
    if (sel == LANE_IDX) begin
      lane_d = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign q = lane_q;

endmodule : demux_lane_reg

// File: rtl/demux_nbit_x4.sv
// Registered 1-to-4 demultiplexer: y is steered to lane a/b/c/d by sel with
// one cycle of latency. Free-running, no handshake and no backpressure.
module demux_nbit_x4
  import demux_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] y,
  input  logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] a,
  output logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] c,
  output logic [BUS_WIDTH-1:0] d
);

  lane_e                sel_lane;
  logic [BUS_WIDTH-1:0] lane_out [NUM_LANES];

  assign sel_lane = lane_e'(sel);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(
      .BUS_WIDTH (BUS_WIDTH),
      .LANE_IDX  (lane_e'(i))
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .y     (y),
      .sel   (sel_lane),
      .q     (lane_out[i])
    );
  end

  assign a = lane_out[0];
  assign b = lane_out[1];
  assign c = lane_out[2];
  assign d = lane_out[3];

  // An unknown select would make the loaded lane ambiguous.
  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(sel))
    else $error("demux_nbit_x4: sel is X/Z while out of reset");

endmodule : demux_nbit_x4

// File: tb/tb_demux_nbit_x4.sv
// Directed self-checking bench for demux_nbit_x4 at BUS_WIDTH=8.
module tb_demux_nbit_x4;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] y;
  logic [1:0]   sel;
  logic [W-1:0] a, b, c, d;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   sel_q[$];

  demux_nbit_x4 #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (y),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic [W-1:0] ec, input logic [W-1:0] ed);
    check({tag, ".a"}, a, ea);
    check({tag, ".b"}, b, eb);
    check({tag, ".c"}, c, ec);
    check({tag, ".d"}, d, ed);
  endtask

  // drive inputs then step one edge; returns 1 time unit after the edge
  task automatic drive_step(input logic [1:0] s, input logic [W-1:0] v);
    sel = s;
    y   = v;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sweep_y [4];
  logic [W-1:0] ev;
  logic [1:0]   es;

  initial begin
    rst_n = 1'b1;
    y     = '0;
    sel   = 2'd0;
    sweep_y[0] = 8'h11;
    sweep_y[1] = 8'h22;
    sweep_y[2] = 8'h33;
    sweep_y[3] = 8'h44;

    // reset held across edges with live inputs
    #1 rst_n = 1'b0;
    y   = 8'hFF;
    sel = 2'd2;
    #1;
    check_lanes("rst_async", 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_lanes("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00);
    end
    rst_n = 1'b1;

    // lane sweep
    drive_step(2'd0, sweep_y[0]);
    check_lanes("sweep0", 8'h11, 8'h00, 8'h00, 8'h00);
    drive_step(2'd1, sweep_y[1]);
    check_lanes("sweep1", 8'h00, 8'h22, 8'h00, 8'h00);
    drive_step(2'd2, sweep_y[2]);
    check_lanes("sweep2", 8'h00, 8'h00, 8'h33, 8'h00);
    drive_step(2'd3, sweep_y[3]);
    check_lanes("sweep3", 8'h00, 8'h00, 8'h00, 8'h44);

    // latency: mid-cycle y change must not reach the output
    drive_step(2'd1, 8'h5A);
    check("lat_first", b, 8'h5A);
    #3 y = 8'hA5;
    #1;
    check("lat_hold", b, 8'h5A);
    @(posedge clk);
    #1;
    check_lanes("lat_next", 8'h00, 8'hA5, 8'h00, 8'h00);

    // lane switch with the same data
    drive_step(2'd3, 8'h7E);
    check_lanes("switch_k", 8'h00, 8'h00, 8'h00, 8'h7E);
    drive_step(2'd0, 8'h7E);
    check_lanes("switch_k1", 8'h7E, 8'h00, 8'h00, 8'h00);

    // zero data clears every lane
    drive_step(2'd2, 8'h00);
    check_lanes("zero_y", 8'h00, 8'h00, 8'h00, 8'h00);

    // async reset between edges
    drive_step(2'd1, 8'hC3);
    check("pre_rst_b", b, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    check_lanes("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    #1 rst_n = 1'b1;
    drive_step(2'd1, 8'h01);
    check_lanes("post_rst", 8'h00, 8'h01, 8'h00, 8'h00);

    // random data, rotating select, scoreboard of expected words
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      y   = W'($urandom_range(0, 255));
      exp_q.push_back(y);
      sel_q.push_back(sel);
      @(posedge clk);
      #1;
      ev = exp_q.pop_front();
      es = sel_q.pop_front();
      check("rnd.a", a, (es == 2'd0) ? ev : 8'h00);
      check("rnd.b", b, (es == 2'd1) ? ev : 8'h00);
      check("rnd.c", c, (es == 2'd2) ? ev : 8'h00);
      check("rnd.d", d, (es == 2'd3) ? ev : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux_nbit_x4

// File: doc/demux_nbit_x4.md
Name: demux_nbit_x4

Overview:
- 1-to-4 demultiplexer for an N-bit bus: input word `y` is steered to one of four output buses (`a`/`b`/`c`/`d`) chosen by 2-bit `sel`.
- Outputs are registered: one clock of latency, clean glitch-free buses for downstream logic.
- Used as a generic routing primitive wherever one producer feeds one of four consumer lanes.

Parameters:
- BUS_WIDTH, 8, width in bits of `y` and of each output bus `a`/`b`/`c`/`d`; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk by the surrounding reset synchronizer.
- y  input  BUS_WIDTH  data word to be routed.
- sel  input  2  lane select: 0→a, 1→b, 2→c, 3→d.
- a  output  BUS_WIDTH  lane 0 output.
- b  output  BUS_WIDTH  lane 1 output.
- c  output  BUS_WIDTH  lane 2 output.
- d  output  BUS_WIDTH  lane 3 output.

Behaviour:
- Reset
  - While rst_n=0, a=b=c=d=0 regardless of clk, y or sel.
  - Reset takes effect asynchronously, without waiting for a clk edge.
- Each rising clk edge with rst_n=1:
  - selected lane register ← y;
  - the three non-selected lane registers ← 0.
  - Exactly one lane may be nonzero at any time; all four are 0 if y=0.
- Latency
  - Exactly 1 cycle: values of y/sel sampled at edge k appear on outputs after edge k and hold until edge k+1.
  - No combinational path from y or sel to any output.
- No enable and no hold state: every cycle re-evaluates.
  - A sel change moves data to the new lane and zeros the old lane in the same cycle.
- Width
  - Data passes bit-exact; no truncation, extension or arithmetic.
  - The output for lane i is y when sel==i, else all-zero of width BUS_WIDTH.
- X handling
  - If sel is X/Z at a sampling edge, outputs are don't-care for that cycle only.
  - Implementation must not latch; simulation assertion flags unknown sel when rst_n=1.
- Reset mid-operation
  - Asserting rst_n between edges clears all outputs immediately.
  - First post-reset edge loads normally per sel/y.
- Back-to-back operation at full clock rate is supported; no handshake, no backpressure.

Decomposition:
- Shared package `demux_pkg`:
  - typedef for lane index (2-bit enum LANE_A=0, LANE_B=1, LANE_C=2, LANE_D=3);
  - constant NUM_LANES=4.
- One natural sub-module, `demux_lane_reg`:
  - a BUS_WIDTH register with async active-low clear;
  - loads y when its lane index matches sel, else loads 0;
  - instantiated four times with lane index parameter 0..3.
- Top level contains only the four instances plus an optional sel-X assertion.

Test Plan (BUS_WIDTH=8):
- Reset: hold rst_n=0, drive y=8'hFF, sel=2, toggle clk 3 times → a=b=c=d=0 throughout.
- Lane sweep: release reset; drive sel=0..3 with y=8'h11,22,33,44 on successive edges.
  - After each edge only the selected lane carries its value, e.g. after sel=2 edge: c=8'h33, a=b=d=0.
- Latency check: change y from 8'h5A to 8'hA5 mid-cycle with sel=1 → b stays 8'h5A until the next rising edge, then becomes 8'hA5.
- Lane switch: sel=3,y=8'h7E at edge k, then sel=0,y=8'h7E at edge k+1.
  - After k: d=8'h7E, others 0.
  - After k+1: a=8'h7E, d=0.
- Async reset mid-run: with b=8'hC3 registered, pull rst_n low between edges → all outputs 0 immediately, before the next clk edge.
  - Release, next edge with sel=1,y=8'h01 → b=8'h01.
- Random: 8 cycles of random y and sel=i%4, reference model compared each cycle → exactly one lane equals the previous-cycle y; the other three are 0.
